// File: rtl/glitch_seq_pkg.sv
// Shared definitions for the glitch sequencer slice.
// Contents:
//   - opcode encodings of the 4-bit instruction opcode field
//   - FSM state encodings (also exported on the debug 'state' port)
//   - fixed field widths (opcode, loop counter, mismatch counter, bus index)
//   - saturating increment helper for the mismatch counter
package glitch_seq_pkg;

    localparam int OPC_W     = 4;
    localparam int LOOP_W    = 16;
    localparam int MCNT_W    = 16;
    localparam int BUS_IDX_W = 4;
    localparam int STATE_W   = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP     = 4'd0,
        OP_PARCEL  = 4'd1,
        OP_MATCH   = 4'd2,
        OP_DAC     = 4'd3,
        OP_DELAY   = 4'd4,
        OP_SETLOOP = 4'd5,
        OP_DJNZ    = 4'd6,
        OP_JUMP    = 4'd7,
        OP_TRIG    = 4'd8,
        OP_HALT    = 4'd9
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_EXEC       = 3'd1,
        ST_MATCH_WAIT = 3'd2,
        ST_DELAY      = 3'd3,
        ST_HALTED     = 3'd4
    } state_e;

    // Mismatch counter sticks at all-ones instead of wrapping.
    function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
        return (v == {MCNT_W{1'b1}}) ? v : v + MCNT_W'(1);
    endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Bundle of all non-clock/reset signals of the glitch sequencer.
// Modports:
//   master - environment side: drives start/abort, snooped bus words and ROM data,
//            observes program address, DAC, trigger and status outputs
//   slave  - sequencer side (the reverse directions)
// Signals:
//   start, abort        control pulses
//   bus_data/bus_valid  NUM_BUS packed snooped bus words and per-bus strobes
//   prog_addr/prog_data program ROM address and combinational read data
//   dac_out/dac_strobe  DAC code and its update pulse
//   trig_out            trigger pulse
//   busy/halted/error   status
//   mismatch_cnt        saturating count of failed matches
//   state               debug state encoding
interface glitch_sequencer_if
    import glitch_seq_pkg::*;
#(
    parameter int NUM_BUS = 2,
    parameter int BUS_W   = 9,
    parameter int DAC_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int ARG_W   = 32
) ();

    logic                     start;
    logic                     abort;
    logic [NUM_BUS*BUS_W-1:0] bus_data;
    logic [NUM_BUS-1:0]       bus_valid;
    logic [ADDR_W-1:0]        prog_addr;
    logic [OPC_W+ARG_W-1:0]   prog_data;
    logic [DAC_W-1:0]         dac_out;
    logic                     dac_strobe;
    logic                     trig_out;
    logic                     busy;
    logic                     halted;
    logic                     error;
    logic [MCNT_W-1:0]        mismatch_cnt;
    logic [STATE_W-1:0]       state;

    modport master (
        output start, abort, bus_data, bus_valid, prog_data,
        input  prog_addr, dac_out, dac_strobe, trig_out, busy, halted, error,
               mismatch_cnt, state
    );

    modport slave (
        input  start, abort, bus_data, bus_valid, prog_data,
        output prog_addr, dac_out, dac_strobe, trig_out, busy, halted, error,
               mismatch_cnt, state
    );

endinterface

// File: rtl/seq_match_unit.sv
// Bus select and masked compare for the MATCH instruction.
// Ports:
//   bus_data_i  NUM_BUS packed bus words, bus i at [i*BUS_W +: BUS_W]
//   bus_valid_i per-bus word strobes
//   bus_sel_i   selected bus index
//   pattern_i   expected word
//   mask_i      1 = bit takes part in the compare
//   hit_o       selected bus strobed and masked word equals pattern
//   miss_o      selected bus strobed and masked word differs
//   bad_idx_o   bus_sel_i does not name an existing bus
module seq_match_unit
    import glitch_seq_pkg::*;
#(
    parameter int NUM_BUS = 2,
    parameter int BUS_W   = 9
) (
    input  logic [NUM_BUS*BUS_W-1:0] bus_data_i,
    input  logic [NUM_BUS-1:0]       bus_valid_i,
    input  logic [BUS_IDX_W-1:0]     bus_sel_i,
    input  logic [BUS_W-1:0]         pattern_i,
    input  logic [BUS_W-1:0]         mask_i,
    output logic                     hit_o,
    output logic                     miss_o,
    output logic                     bad_idx_o
);

    localparam logic [BUS_IDX_W:0] NUM_BUS_L = (BUS_IDX_W + 1)'(NUM_BUS);

    logic [BUS_W-1:0] word_sel;
    logic             valid_sel;
    logic             equal;

    always_comb begin
        word_sel  = '0;
        valid_sel = 1'b0;
        for (int i = 0; i < NUM_BUS; i++) begin
            if (bus_sel_i == BUS_IDX_W'(i)) begin
                word_sel  = bus_data_i[i*BUS_W +: BUS_W];
                valid_sel = bus_valid_i[i];
            end
        end
    end

    assign bad_idx_o = ({1'b0, bus_sel_i} >= NUM_BUS_L);
    assign equal     = (((word_sel ^ pattern_i) & mask_i) == '0);
    assign hit_o     = valid_sel &  equal & ~bad_idx_o;
    assign miss_o    = valid_sel & ~equal & ~bad_idx_o;

endmodule

// File: rtl/glitch_sequencer.sv
// Programmable glitch sequencer: fetches instructions from an external ROM,
// waits for masked matches on snooped buses, drives the core-voltage DAC,
// times delays, runs counted loops and emits trigger pulses.
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   bus_if  glitch_sequencer_if.slave (control, buses, ROM, DAC, trigger, status)
// ARG_W must be >= max(DELAY_W, 2*BUS_W+4, ADDR_W, 16, DAC_W).
module glitch_sequencer
    import glitch_seq_pkg::*;
#(
    parameter int NUM_BUS = 2,
    parameter int BUS_W   = 9,
    parameter int DAC_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int DELAY_W = 32,
    parameter int ARG_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    glitch_sequencer_if.slave  bus_if
);

    localparam int MASK_LSB = BUS_W;
    localparam int BUS_LSB  = 2 * BUS_W;

    state_e               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    parcel_q;
    logic [LOOP_W-1:0]    loop_q;
    logic [DELAY_W-1:0]   delay_q;
    logic [BUS_W-1:0]     pattern_q;
    logic [BUS_W-1:0]     mask_q;
    logic [BUS_IDX_W-1:0] bus_q;
    logic [DAC_W-1:0]     dac_q;
    logic                 dac_strobe_q;
    logic                 trig_q;
    logic                 error_q;
    logic [MCNT_W-1:0]    mism_q;

    logic [OPC_W-1:0]     opc;
    logic [ARG_W-1:0]     arg;
    logic [BUS_IDX_W-1:0] arg_bus;
    logic [BUS_IDX_W-1:0] bus_sel;
    logic [ADDR_W-1:0]    pc_inc_d;
    logic                 hit;
    logic                 miss;
    logic                 bad_idx;
    logic                 unused_arg;

    assign opc        = bus_if.prog_data[ARG_W+OPC_W-1:ARG_W];
    assign arg        = bus_if.prog_data[ARG_W-1:0];
    assign arg_bus    = arg[BUS_LSB +: BUS_IDX_W];
    assign pc_inc_d   = pc_q + ADDR_W'(1);
    assign unused_arg = ^arg;

    // The index is range-checked while MATCH is being decoded, and the
    // latched copy drives the compare while waiting.
    assign bus_sel = (state_q == ST_EXEC) ? arg_bus : bus_q;

    seq_match_unit #(
        .NUM_BUS (NUM_BUS),
        .BUS_W   (BUS_W)
    ) u_match (
        .bus_data_i  (bus_if.bus_data),
        .bus_valid_i (bus_if.bus_valid),
        .bus_sel_i   (bus_sel),
        .pattern_i   (pattern_q),
        .mask_i      (mask_q),
        .hit_o       (hit),
        .miss_o      (miss),
        .bad_idx_o   (bad_idx)
    );

    // Strobes default low each cycle so DAC/TRIG give single-cycle pulses and
    // abort forces them low. dac_out is never touched by start or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            parcel_q     <= '0;
            loop_q       <= '0;
            delay_q      <= '0;
            pattern_q    <= '0;
            mask_q       <= '0;
            bus_q        <= '0;
            dac_q        <= '0;
            dac_strobe_q <= 1'b0;
            trig_q       <= 1'b0;
            error_q      <= 1'b0;
            mism_q       <= '0;
        end else begin
            dac_strobe_q <= 1'b0;
            trig_q       <= 1'b0;
            if (bus_if.abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_HALTED: begin
                        if (bus_if.start) begin
                            pc_q     <= '0;
                            parcel_q <= '0;
                            mism_q   <= '0;
                            error_q  <= 1'b0;
                            state_q  <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        case (opc)
                            OP_NOP: pc_q <= pc_inc_d;
                            OP_PARCEL: begin
                                parcel_q <= pc_q;
                                pc_q     <= pc_inc_d;
                            end
                            OP_MATCH: begin
                                if (bad_idx) begin
                                    error_q <= 1'b1;
                                    state_q <= ST_HALTED;
                                end else begin
                                    pattern_q <= arg[BUS_W-1:0];
                                    mask_q    <= arg[MASK_LSB +: BUS_W];
                                    bus_q     <= arg_bus;
                                    state_q   <= ST_MATCH_WAIT;
                                end
                            end
                            OP_DAC: begin
                                dac_q        <= arg[DAC_W-1:0];
                                dac_strobe_q <= 1'b1;
                                pc_q         <= pc_inc_d;
                            end
                            OP_DELAY: begin
                                if (arg[DELAY_W-1:0] == '0) begin
                                    pc_q <= pc_inc_d;
                                end else begin
                                    delay_q <= arg[DELAY_W-1:0];
                                    state_q <= ST_DELAY;
                                end
                            end
                            OP_SETLOOP: begin
                                loop_q <= arg[LOOP_W-1:0];
                                pc_q   <= pc_inc_d;
                            end
                            OP_DJNZ: begin
                                if (loop_q != '0) begin
                                    loop_q <= loop_q - LOOP_W'(1);
                                    pc_q   <= arg[ADDR_W-1:0];
                                end else begin
                                    pc_q <= pc_inc_d;
                                end
                            end
                            OP_JUMP: pc_q <= arg[ADDR_W-1:0];
                            OP_TRIG: begin
                                trig_q <= 1'b1;
                                pc_q   <= pc_inc_d;
                            end
                            OP_HALT: state_q <= ST_HALTED;
                            default: begin
                                error_q <= 1'b1;
                                state_q <= ST_HALTED;
                            end
                        endcase
                    end
                    ST_MATCH_WAIT: begin
                        if (hit) begin
                            pc_q    <= pc_inc_d;
                            state_q <= ST_EXEC;
                        end else if (miss) begin
                            pc_q    <= parcel_q;
                            mism_q  <= sat_inc(mism_q);
                            state_q <= ST_EXEC;
                        end
                    end
                    ST_DELAY: begin
                        // Counter loaded with n; leaving on 1 gives exactly n cycles here.
                        if (delay_q == DELAY_W'(1)) begin
                            pc_q    <= pc_inc_d;
                            state_q <= ST_EXEC;
                        end else begin
                            delay_q <= delay_q - DELAY_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus_if.prog_addr    = pc_q;
    assign bus_if.dac_out      = dac_q;
    assign bus_if.dac_strobe   = dac_strobe_q;
    assign bus_if.trig_out     = trig_q;
    assign bus_if.busy         = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign bus_if.halted       = (state_q == ST_HALTED);
    assign bus_if.error        = error_q;
    assign bus_if.mismatch_cnt = mism_q;
    assign bus_if.state        = state_q;

endmodule
